// File: rtl/mac_pkg.sv
// Shared types for the dot-product sequencing controller.
// Provides the FSM state enum and its encoding width.
package mac_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Control/status bundle of mac_seq_ctrl.
// master: start/cfg/stall source; slave: the controller.
interface mac_seq_ctrl_if #(
  parameter int D_W   = 4,
  parameter int Q_W   = 4,
  parameter int LANES = 2
);

  logic             st;
  logic [D_W-1:0]   cfg_d_last;
  logic [Q_W-1:0]   cfg_q_last;
  logic             stall;
  logic             busy;
  logic             done;
  logic             mem_rd;
  logic [D_W-1:0]   index_d;
  logic [Q_W-1:0]   addr_q;
  logic [LANES-1:0] lane_valid;
  logic             acc_en;
  logic             clear_acc;
  logic             res_write;
  logic [Q_W-1:0]   res_addr;

  modport master (
    output st, cfg_d_last, cfg_q_last, stall,
    input  busy, done, mem_rd, index_d, addr_q,
    input  lane_valid, acc_en, clear_acc,
    input  res_write, res_addr
  );

  modport slave (
    input  st, cfg_d_last, cfg_q_last, stall,
    output busy, done, mem_rd, index_d, addr_q,
    output lane_valid, acc_en, clear_acc,
    output res_write, res_addr
  );

endinterface

// File: rtl/mac_lane_mask.sv
// Lane enable mask: lane i valid iff addr_q+i <= q_last.
// Ports: addr_q, q_last in; lane_valid out (LANES bits).
module mac_lane_mask #(
  parameter int Q_W   = 4,
  parameter int LANES = 2
) (
  input  logic [Q_W-1:0]   addr_q,
  input  logic [Q_W-1:0]   q_last,
  output logic [LANES-1:0] lane_valid
);

  typedef logic [Q_W:0] wide_t;

  // One extra bit so addr_q+i never wraps.
  always_comb begin
    lane_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_valid[i] =
        ({1'b0, addr_q} + wide_t'(i))
        <= {1'b0, q_last};
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: LANES outputs per group.
// Ports: clk, rst (sync, high), bus (slave modport).
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int D_W   = 4,
  parameter int Q_W   = 4,
  parameter int LANES = 2
) (
  input logic          clk,
  input logic          rst,
  mac_seq_ctrl_if.slave bus
);

  typedef logic [Q_W:0] wide_t;
  localparam wide_t LN = wide_t'(LANES);

  state_t           state;
  logic [D_W-1:0]   d_cnt;
  logic [D_W-1:0]   d_last;
  logic [Q_W-1:0]   addr_q;
  logic [Q_W-1:0]   q_last;
  logic             acc_en;
  logic             mem_rd;
  logic             busy;
  logic             done;
  logic             clear_acc;
  logic             res_write;
  logic             last_grp;
  logic [LANES-1:0] mask;

  // Wide compare keeps addr_q from wrapping.
  assign last_grp =
    ({1'b0, addr_q} + LN) > {1'b0, q_last};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      d_cnt  <= '0;
      d_last <= '0;
      addr_q <= '0;
      q_last <= '0;
      acc_en <= 1'b0;
    end else begin
      acc_en <= mem_rd;
      unique case (state)
        IDLE: begin
          if (bus.st) begin
            d_last <= bus.cfg_d_last;
            q_last <= bus.cfg_q_last;
            d_cnt  <= '0;
            addr_q <= '0;
            state  <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (!bus.stall) begin
            if (d_cnt == d_last) begin
              d_cnt <= '0;
              state <= DRAIN;
            end else begin
              d_cnt <= d_cnt + 1'b1;
            end
          end
        end
        DRAIN: state <= WRITE;
        WRITE: begin
          if (last_grp) begin
            state <= DONE;
          end else begin
            addr_q <= addr_q + LN[Q_W-1:0];
            state  <= RUN;
          end
        end
        DONE: begin
          addr_q <= '0;
          state  <= IDLE;
        end
        default: begin
          d_cnt  <= '0;
          addr_q <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    clear_acc = 1'b0;
    res_write = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        busy      = 1'b1;
        clear_acc = 1'b1;
      end
      RUN: begin
        busy   = 1'b1;
        mem_rd = !bus.stall;
      end
      DRAIN: busy = 1'b1;
      WRITE: begin
        busy      = 1'b1;
        res_write = 1'b1;
        clear_acc = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  mac_lane_mask #(
    .Q_W   (Q_W),
    .LANES (LANES)
  ) u_mask (
    .addr_q     (addr_q),
    .q_last     (q_last),
    .lane_valid (mask)
  );

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.mem_rd     = mem_rd;
  assign bus.acc_en     = acc_en;
  assign bus.clear_acc  = clear_acc;
  assign bus.res_write  = res_write;
  assign bus.index_d    = busy ? d_cnt : '0;
  assign bus.addr_q     = busy ? addr_q : '0;
  assign bus.lane_valid = busy ? mask : '0;
  assign bus.res_addr   = res_write ? addr_q : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl.
// Two instances: LANES=2 (main) and LANES=4.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.D_W(4), .Q_W(4), .LANES(2)) ba ();
  mac_seq_ctrl_if #(.D_W(4), .Q_W(4), .LANES(4)) bb ();

  mac_seq_ctrl #(.D_W(4), .Q_W(4), .LANES(2)) dut (
    .clk (clk), .rst (rst), .bus (ba)
  );
  mac_seq_ctrl #(.D_W(4), .Q_W(4), .LANES(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bb)
  );

  typedef struct { int a; int l; } wr_t;
  typedef struct { int busy; int acc; } run_t;

  int errs = 0;
  int checks = 0;
  int   q_rd[$];
  wr_t  q_wr[$];
  run_t q_run[$];
  wr_t  q_wr4[$];
  int   q_run4[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor for the LANES=2 instance.
  logic prv_rd = 1'b0;
  logic prv_rst = 1'b1;
  int bcnt = 0;
  int acnt = 0;
  always @(negedge clk) begin : mon_a
    wr_t w;
    run_t r;
    chk("acc_en", int'(ba.acc_en),
        prv_rst ? 0 : int'(prv_rd));
    prv_rd = ba.mem_rd;
    prv_rst = rst;
    if (ba.mem_rd) begin
      if (q_rd.size() == 0) chk("rd_extra", 1, 0);
      else chk("index_d", int'(ba.index_d), q_rd.pop_front());
    end
    if (ba.res_write) begin
      if (q_wr.size() == 0) chk("wr_extra", 1, 0);
      else begin
        w = q_wr.pop_front();
        chk("res_addr", int'(ba.res_addr), w.a);
        chk("lane_valid", int'(ba.lane_valid), w.l);
      end
    end
    if (ba.busy) begin
      bcnt++;
      acnt += int'(ba.acc_en);
    end
    if (ba.done) begin
      if (q_run.size() == 0) chk("done_extra", 1, 0);
      else begin
        r = q_run.pop_front();
        chk("busy_cycles", bcnt, r.busy);
        chk("acc_pulses", acnt, r.acc);
      end
    end
    if (!ba.busy) begin
      bcnt = 0;
      acnt = 0;
    end
  end

  // Monitor for the LANES=4 instance.
  int bcnt4 = 0;
  always @(negedge clk) begin : mon_b
    wr_t w;
    if (bb.res_write) begin
      if (q_wr4.size() == 0) chk("wr4_extra", 1, 0);
      else begin
        w = q_wr4.pop_front();
        chk("res_addr4", int'(bb.res_addr), w.a);
        chk("lane_valid4", int'(bb.lane_valid), w.l);
      end
    end
    if (bb.busy) bcnt4++;
    if (bb.done) begin
      if (q_run4.size() == 0) chk("done4_extra", 1, 0);
      else chk("busy_cycles4", bcnt4, q_run4.pop_front());
    end
    if (!bb.busy) bcnt4 = 0;
  end

  task automatic start_a(int d, int q);
    @(posedge clk); #1;
    ba.cfg_d_last = 4'(d);
    ba.cfg_q_last = 4'(q);
    ba.st = 1'b1;
    @(posedge clk); #1;
    ba.st = 1'b0;
  endtask

  task automatic start_b(int d, int q);
    @(posedge clk); #1;
    bb.cfg_d_last = 4'(d);
    bb.cfg_q_last = 4'(q);
    bb.st = 1'b1;
    @(posedge clk); #1;
    bb.st = 1'b0;
  endtask

  task automatic wait_a(int max);
    int n = 0;
    while (ba.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_a", int'(n >= max), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_b(int max);
    int n = 0;
    while (bb.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_b", int'(n >= max), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int outs_a();
    return int'({ba.busy, ba.done, ba.mem_rd,
                 ba.index_d, ba.addr_q, ba.lane_valid,
                 ba.acc_en, ba.clear_acc,
                 ba.res_write, ba.res_addr});
  endfunction

  function automatic int outs_b();
    return int'({bb.busy, bb.done, bb.mem_rd,
                 bb.index_d, bb.addr_q, bb.lane_valid,
                 bb.acc_en, bb.clear_acc,
                 bb.res_write, bb.res_addr});
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    ba.st = 1'b0; ba.stall = 1'b0;
    ba.cfg_d_last = '0; ba.cfg_q_last = '0;
    bb.st = 1'b0; bb.stall = 1'b0;
    bb.cfg_d_last = '0; bb.cfg_q_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_a", outs_a(), 0);
    chk("reset_outs_b", outs_b(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic: d_last=2, q_last=1.
    q_rd = '{0, 1, 2};
    q_wr.push_back('{0, 3});
    q_run.push_back('{7, 3});
    start_a(2, 1);
    wait_a(50);

    // Three groups, d_last=0.
    q_rd = '{0, 0, 0};
    q_wr.push_back('{0, 3});
    q_wr.push_back('{2, 3});
    q_wr.push_back('{4, 1});
    q_run.push_back('{11, 3});
    start_a(0, 4);
    wait_a(50);

    // Stall on RUN cycles 2 and 3.
    q_rd = '{0, 1, 2, 3};
    q_wr.push_back('{0, 3});
    q_run.push_back('{10, 4});
    start_a(3, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ba.stall = 1'b1;
    @(negedge clk);
    chk("stall_idx1", int'(ba.index_d), 1);
    chk("stall_rd1", int'(ba.mem_rd), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_idx2", int'(ba.index_d), 1);
    @(posedge clk); #1;
    ba.stall = 1'b0;
    wait_a(50);

    // Abort with rst while d_cnt=2.
    q_rd = '{0, 1, 2};
    start_a(5, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idx", int'(ba.index_d), 2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", outs_a(), 0);
    q_rd = '{0, 1};
    q_wr.push_back('{0, 3});
    q_run.push_back('{6, 2});
    start_a(1, 1);
    wait_a(50);

    // st held and re-pulsed: one run only.
    q_rd = '{0, 1};
    q_wr.push_back('{0, 3});
    q_run.push_back('{6, 2});
    @(posedge clk); #1;
    ba.cfg_d_last = 4'd1;
    ba.cfg_q_last = 4'd1;
    ba.st = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    ba.st = 1'b0;
    @(posedge clk); #1;
    ba.st = 1'b1;
    @(posedge clk); #1;
    ba.st = 1'b0;
    wait_a(50);
    repeat (3) @(negedge clk);
    chk("no_rerun", int'(ba.busy), 0);

    // LANES=4, full output range.
    q_wr4.push_back('{0, 15});
    q_wr4.push_back('{4, 15});
    q_wr4.push_back('{8, 15});
    q_wr4.push_back('{12, 15});
    q_run4.push_back(18);
    start_b(1, 15);
    wait_b(80);

    repeat (3) @(negedge clk);
    chk("leftover",
        q_rd.size() + q_wr.size() + q_run.size()
        + q_wr4.size() + q_run4.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
